// File: rtl/mask_pkg.sv
// Shared types and helpers for the mask row sequencer: FSM states, resolution codes
// and the per-resolution beat/row lookups.
package mask_pkg;

  localparam int BEAT_W    = 6;
  localparam int ROW_IDX_W = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_LOAD,
    S_PRIME,
    S_SHIFT,
    S_ROW_END
  } seq_state_t;

  typedef enum logic [1:0] {
    RES0     = 2'd0,
    RES1     = 2'd1,
    RES2     = 2'd2,
    RES_RSVD = 2'd3
  } mask_res_t;

  function automatic logic [BEAT_W-1:0] step_for_res(input mask_res_t res,
                                                     input int s0, input int s1, input int s2);
    case (res)
      RES0:    step_for_res = BEAT_W'(s0);
      RES1:    step_for_res = BEAT_W'(s1);
      RES2:    step_for_res = BEAT_W'(s2);
      default: step_for_res = '0;
    endcase
  endfunction

  function automatic logic [ROW_IDX_W-1:0] rows_for_res(input mask_res_t res,
                                                        input int r0, input int r1, input int r2);
    case (res)
      RES0:    rows_for_res = ROW_IDX_W'(r0);
      RES1:    rows_for_res = ROW_IDX_W'(r1);
      RES2:    rows_for_res = ROW_IDX_W'(r2);
      default: rows_for_res = '0;
    endcase
  endfunction

endpackage

// File: rtl/mask_row_sequencer_if.sv
// Row-source, serializer and beat-sink signals of the mask row sequencer.
// master is the sequencer's view; slave is the view of its surroundings.
interface mask_row_sequencer_if #(
  parameter int IP_CHANNEL_WIDTH = 640,
  parameter int OP_CHANNEL_WIDTH = 20
);

  logic                        row_valid;
  logic [IP_CHANNEL_WIDTH-1:0] row_data;
  logic                        row_ready;

  logic [IP_CHANNEL_WIDTH-1:0] ser_din;
  logic                        ser_load;
  logic                        ser_next;
  logic [1:0]                  ser_res;
  logic                        ser_done;
  logic [OP_CHANNEL_WIDTH-1:0] ser_dout;

  logic [OP_CHANNEL_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        dout_ready;

  modport master (
    input  row_valid, row_data, ser_done, ser_dout, dout_ready,
    output row_ready, ser_din, ser_load, ser_next, ser_res, dout, dout_valid
  );

  modport slave (
    output row_valid, row_data, ser_done, ser_dout, dout_ready,
    input  row_ready, ser_din, ser_load, ser_next, ser_res, dout, dout_valid
  );

endinterface

// File: rtl/mask_row_sequencer.sv
// Frame-level controller for mask_serializer: accepts one row at a time, walks the
// serializer through its beats with downstream backpressure and counts rows per frame.
module mask_row_sequencer
  import mask_pkg::*;
#(
  parameter int IP_CHANNEL_WIDTH = 640,
  parameter int OP_CHANNEL_WIDTH = 20,
  parameter int stepSel0         = 16,
  parameter int stepSel1         = 32,
  parameter int stepSel2         = 54,
  parameter int ROWS0            = 240,
  parameter int ROWS1            = 480,
  parameter int ROWS2            = 720
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           imageResolution,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err,
  output logic                 sync_err,
  output logic [ROW_IDX_W-1:0] row_idx,
  mask_row_sequencer_if.master bus
);

  seq_state_t                  r_state;
  mask_res_t                   r_res;
  logic [BEAT_W-1:0]           r_step;
  logic [ROW_IDX_W-1:0]        r_rows;
  logic [BEAT_W-1:0]           r_beat;
  logic [ROW_IDX_W-1:0]        r_row_idx;
  logic [IP_CHANNEL_WIDTH-1:0] r_ser_din;
  logic                        r_row_ready;
  logic                        r_ser_load;
  logic                        r_frame_done;
  logic                        r_cfg_err;
  logic                        r_sync_err;

  mask_res_t                   w_req_res;
  logic                        w_shift;
  logic                        w_last_beat;
  logic                        w_last_row;
  logic [OP_CHANNEL_WIDTH-1:0] w_dout;

  assign w_req_res   = mask_res_t'(imageResolution);
  assign w_shift     = (r_state == S_SHIFT);
  assign w_last_beat = (r_beat == (r_step - BEAT_W'(1)));
  assign w_last_row  = (r_row_idx == (r_rows - ROW_IDX_W'(1)));
  assign w_dout      = bus.ser_dout;

  // One-cycle outputs default low each cycle and are raised only on the transition
  // that enters the state they decode; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_res        <= RES0;
      r_step       <= '0;
      r_rows       <= '0;
      r_beat       <= '0;
      r_row_idx    <= '0;
      r_ser_din    <= '0;
      r_row_ready  <= 1'b0;
      r_ser_load   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_row_ready  <= 1'b0;
      r_ser_load   <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_req_res == RES_RSVD) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_res       <= w_req_res;
                r_step      <= step_for_res(w_req_res, stepSel0, stepSel1, stepSel2);
                r_rows      <= rows_for_res(w_req_res, ROWS0, ROWS1, ROWS2);
                r_row_idx   <= '0;
                r_sync_err  <= 1'b0;
                r_row_ready <= 1'b1;
                r_state     <= S_WAIT_ROW;
              end
            end
          end
          S_WAIT_ROW: begin
            if (bus.row_valid && r_row_ready) begin
              r_ser_din  <= bus.row_data;
              r_ser_load <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_row_ready <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state <= S_PRIME;
          end
          S_PRIME: begin
            r_beat  <= '0;
            r_state <= S_SHIFT;
          end
          S_SHIFT: begin
            if (bus.dout_ready) begin
              if (w_last_beat) begin
                r_state <= S_ROW_END;
              end else begin
                r_beat <= r_beat + BEAT_W'(1);
              end
            end
          end
          S_ROW_END: begin
            // The serializer should have just finished its row; flag it if not.
            if (!bus.ser_done) begin
              r_sync_err <= 1'b1;
            end
            if (w_last_row) begin
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_row_idx   <= r_row_idx + ROW_IDX_W'(1);
              r_row_ready <= 1'b1;
              r_state     <= S_WAIT_ROW;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign frame_done     = r_frame_done;
  assign cfg_err        = r_cfg_err;
  assign sync_err       = r_sync_err;
  assign row_idx        = r_row_idx;

  assign bus.row_ready  = r_row_ready;
  assign bus.ser_din    = r_ser_din;
  assign bus.ser_load   = r_ser_load;
  assign bus.ser_res    = r_res;
  assign bus.ser_next   = w_shift && bus.dout_ready;
  assign bus.dout_valid = w_shift;
  assign bus.dout       = w_dout;

endmodule

// File: tb/tb_mask_row_sequencer.sv
// Self-checking bench for mask_row_sequencer with a behavioural serializer stub and a
// beat-stream reference model built from accepted rows.
`timescale 1ns/1ps
module tb_mask_row_sequencer;
  import mask_pkg::*;

  localparam int IPW    = 640;
  localparam int OPW    = 20;
  localparam int STEP0  = 16;
  localparam int STEP1  = 32;
  localparam int STEP2  = 54;
  localparam int NROWS0 = 2;
  localparam int NROWS1 = 3;
  localparam int NROWS2 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  imageResolution = 2'd0;
  logic        busy, frame_done, cfg_err, sync_err;
  logic [10:0] row_idx;

  mask_row_sequencer_if #(.IP_CHANNEL_WIDTH(IPW), .OP_CHANNEL_WIDTH(OPW)) bus ();

  mask_row_sequencer #(
    .IP_CHANNEL_WIDTH(IPW), .OP_CHANNEL_WIDTH(OPW),
    .stepSel0(STEP0), .stepSel1(STEP1), .stepSel2(STEP2),
    .ROWS0(NROWS0), .ROWS1(NROWS1), .ROWS2(NROWS2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .imageResolution(imageResolution), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .sync_err(sync_err), .row_idx(row_idx), .bus(bus)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  function automatic int stepOf(input int res);
    case (res)
      0: return STEP0;
      1: return STEP1;
      2: return STEP2;
      default: return 0;
    endcase
  endfunction

  function automatic int rowsOf(input int res);
    case (res)
      0: return NROWS0;
      1: return NROWS1;
      2: return NROWS2;
      default: return 0;
    endcase
  endfunction

  // Serializer stub: load captures DIN, next advances, done once a full row was shifted.
  logic [IPW-1:0] stubRow;
  int             stubIdx;
  bit             forceDoneLow = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      stubRow <= '0;
      stubIdx <= 0;
    end else if (bus.ser_load) begin
      stubRow <= bus.ser_din;
      stubIdx <= 0;
    end else if (bus.ser_next) begin
      stubIdx <= stubIdx + 1;
    end
  end

  always_comb begin
    bus.ser_dout = '0;
    if (stubIdx < IPW / OPW) bus.ser_dout = stubRow[stubIdx*OPW +: OPW];
  end

  assign bus.ser_done = !forceDoneLow && (stubIdx >= stepOf(int'(bus.ser_res)));

  logic [OPW-1:0] beatQ[$];

  function automatic logic [IPW-1:0] randRow();
    logic [IPW-1:0] r;
    for (int i = 0; i < IPW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [OPW-1:0] beatOf(input logic [IPW-1:0] row, input int k);
    logic [OPW-1:0] b;
    b = '0;
    if (k < IPW / OPW) b = row[k*OPW +: OPW];
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [IPW-1:0] actual,
                             input logic [IPW-1:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " row_ready"}, bus.row_ready, 0);
    checkOutput({tag, " ser_load"}, bus.ser_load, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " cfg_err"}, cfg_err, 0);
    checkOutput({tag, " sync_err"}, sync_err, 0);
    checkOutput({tag, " row_idx"}, row_idx, 0);
    checkOutput({tag, " ser_din"}, bus.ser_din, 0);
    checkOutput({tag, " ser_res"}, bus.ser_res, 0);
    checkOutput({tag, " dout_valid"}, bus.dout_valid, 0);
    checkOutput({tag, " ser_next"}, bus.ser_next, 0);
  endtask

  // Runs one frame (or a reserved-resolution start). Inputs change on negedges; a
  // handshake or beat seen before an edge is taken by the DUT on that edge.
  task automatic applyStimulus(input int res, input int stallRow, input int stallBeat,
                               input int stallLen, input int abortRow, input int abortBeat,
                               input bit randMode, input int expCycles, input bit expSync);
    int step, nrows, cycles, rowsIn, rowsDone, beatsInRow, totalBeats, stallLeft;
    int primeAt, validAt, doneCount;
    bit hsPending, abortPending, doneSeen, aborted, readyNext;
    logic [IPW-1:0] curRow, lastRow;
    step = stepOf(res);
    nrows = rowsOf(res);
    beatQ.delete();
    @(negedge clk);
    imageResolution = 2'(res);
    start = 1'b1;
    if (res == 3) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput("cfg_err pulse", cfg_err, 1);
      checkOutput("cfg_err busy", busy, 0);
      checkOutput("cfg_err row_ready", bus.row_ready, 0);
      @(negedge clk);
      checkOutput("cfg_err one cycle", cfg_err, 0);
      checkOutput("cfg_err still idle", busy, 0);
      return;
    end
    curRow = randRow();
    lastRow = '0;
    bus.row_data = curRow;
    bus.row_valid = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.dout_ready = 1'b1;
    cycles = 0; rowsIn = 0; rowsDone = 0; beatsInRow = 0; totalBeats = 0;
    stallLeft = stallLen; primeAt = -1; validAt = -1;
    hsPending = 0; abortPending = 0; doneSeen = 0; aborted = 0;
    while (!doneSeen && !aborted && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      abort = 1'b0;
      if (abortPending) begin
        aborted = 1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort frame_done", frame_done, 0);
        checkOutput("abort ser_din kept", bus.ser_din, lastRow);
        doneCount = 0;
        repeat (5) begin
          @(negedge clk);
          if (frame_done) doneCount++;
        end
        checkOutput("abort no frame_done", doneCount, 0);
        break;
      end
      if (hsPending) begin
        checkOutput("ser_load latency", bus.ser_load, 1);
        for (int k = 0; k < step; k++) beatQ.push_back(beatOf(curRow, k));
        lastRow = curRow;
        rowsIn++;
        primeAt = cycles + 1;
        validAt = cycles + 2;
        curRow = randRow();
        bus.row_data = curRow;
      end
      if (cycles == primeAt) checkOutput("dout_valid before prime", bus.dout_valid, 0);
      if (cycles == validAt) checkOutput("first dout_valid latency", bus.dout_valid, 1);
      if (frame_done) begin
        doneSeen = 1;
        break;
      end
      readyNext = randMode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rowsDone == stallRow && beatsInRow == stallBeat && stallLeft > 0 && bus.dout_valid) begin
        readyNext = 1'b0;
        stallLeft--;
      end
      if (rowsDone == abortRow && beatsInRow == abortBeat && bus.dout_valid) begin
        abort = 1'b1;
        readyNext = 1'b0;
        abortPending = 1;
      end
      bus.dout_ready = readyNext;
      if (randMode) bus.row_valid = 1'($urandom_range(0, 1));
      #1;
      if (bus.dout_valid) checkOutput("ser_next follows dout_ready", bus.ser_next, bus.dout_ready);
      if (bus.dout_valid && bus.dout_ready) begin
        if (beatQ.size() == 0) begin
          checkOutput("unexpected beat", 1, 0);
        end else begin
          checkOutput("beat data", bus.dout, beatQ.pop_front());
        end
        totalBeats++;
        beatsInRow++;
        if (beatsInRow == step) begin
          beatsInRow = 0;
          rowsDone++;
        end
      end
      hsPending = bus.row_valid && bus.row_ready;
      if (hsPending) begin
        checkOutput("row_idx at handshake", row_idx, rowsIn);
        checkOutput("sync_err at handshake", sync_err, expSync && rowsIn > 0);
        checkOutput("ser_res latched", bus.ser_res, res);
      end
    end
    if (!aborted) begin
      checkOutput("frame_done seen", doneSeen, 1);
      if (doneSeen) begin
        if (expCycles >= 0) checkOutput("frame_done cycle", cycles, expCycles);
        checkOutput("beats per frame", totalBeats, nrows * step);
        checkOutput("model drained", beatQ.size(), 0);
        checkOutput("busy falls with frame_done", busy, 0);
        checkOutput("sync_err at frame_done", sync_err, expSync);
        @(negedge clk);
        checkOutput("frame_done one cycle", frame_done, 0);
      end
    end
    bus.row_valid = 1'b0;
  endtask

  typedef struct {
    int res;
    int stallRow;
    int stallBeat;
    int stallLen;
    int expCycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int waitCycles;
    vecs[0] = '{1, -1, 0, 0, 109};
    vecs[1] = '{0, -1, 0, 0, 41};
    vecs[2] = '{2, -1, 0, 0, 117};
    vecs[3] = '{1, 0, 10, 5, 114};
    vecs[4] = '{3, -1, 0, 0, 0};

    bus.row_valid = 1'b0;
    bus.row_data = '0;
    bus.dout_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", busy, 0);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d: res %0d", i, vecs[i].res);
      applyStimulus(vecs[i].res, vecs[i].stallRow, vecs[i].stallBeat, vecs[i].stallLen,
                    -1, 0, 1'b0, vecs[i].expCycles, 1'b0);
    end

    $display("[TB] abort at beat 7 of row 1, then restart");
    applyStimulus(1, -1, 0, 0, 1, 7, 1'b0, -1, 1'b0);
    applyStimulus(1, -1, 0, 0, -1, 0, 1'b0, 109, 1'b0);

    $display("[TB] serializer done held low");
    forceDoneLow = 1'b1;
    applyStimulus(0, -1, 0, 0, -1, 0, 1'b0, 41, 1'b1);
    forceDoneLow = 1'b0;
    applyStimulus(0, -1, 0, 0, -1, 0, 1'b0, 41, 1'b0);

    $display("[TB] reset during SHIFT");
    @(negedge clk);
    imageResolution = 2'd1;
    start = 1'b1;
    bus.row_data = randRow();
    bus.row_valid = 1'b1;
    bus.dout_ready = 1'b1;
    waitCycles = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      waitCycles++;
    end while (!bus.dout_valid && waitCycles < 20);
    checkOutput("reached SHIFT", bus.dout_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("mid-frame reset");
    rst_n = 1'b1;
    bus.row_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle after mid-frame reset", busy, 0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(int'($urandom_range(0, 2)), -1, 0, 0, -1, 0, 1'b1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
